seq_addsub_rca: RTL and testbench



---
 rtl/seq_addsub_rca.sv | 130 +++++++++++++
 tb/tb_seq_addsub_rca.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub_rca.sv
// Multi-cycle ripple-carry adder/subtractor: CHUNK bits per clock, LSB chunk first,
// with a start/busy/done handshake. Results appear only on the edge entering DONE.
module seq_addsub_rca #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    int unsigned      lo;
    logic             last;
    logic [CHUNK-1:0] ca, cb, cs;
    logic [CHUNK:0]   c;

    assign lo   = int'(k_q) * CHUNK;
    assign last = (k_q == KW'(N - 1));
    assign ca   = a_q[lo +: CHUNK];
    assign cb   = b_q[lo +: CHUNK];
    assign c[0] = carry_q;

    // One CHUNK-bit ripple chain, reused for every chunk of the operation.
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign cs[i]  = ca[i] ^ cb[i] ^ c[i];
        assign c[i+1] = (ca[i] & cb[i]) | (c[i] & (ca[i] ^ cb[i]));
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                res_d[lo +: CHUNK] = cs;
                carry_d            = c[CHUNK];
                if (last) begin
                    sum_d   = res_d;
                    cout_d  = c[CHUNK];
                    ovf_d   = c[CHUNK] ^ c[CHUNK-1];
                    state_d = StDone;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StDone: begin
                state_d = start ? StRun : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Subtract is a + ~b + ~cin, i.e. a - b - cin in two's complement.
        if (start && (state_q == StIdle || state_q == StDone)) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub ? ~cin : cin;
            k_d     = '0;
            res_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_addsub_rca.sv
// Bench for seq_addsub_rca: directed plan vectors, random operations against an
// arithmetic reference model, handshake corner cases and mid-run reset.
module tb_seq_addsub_rca;

    localparam int W = 16;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int n_cmp = 0;
    int n_err = 0;

    seq_addsub_rca dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Returns {cout, ovf, sum} from plain integer arithmetic and the sign rule.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic ms, input logic mc);
        logic [W:0]   full;
        logic [W-1:0] be;
        logic         o;
        be   = ms ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, (ms ? ~mc : mc)};
        o    = (ma[W-1] == be[W-1]) && (full[W-1] != ma[W-1]);
        return {full[W], o, full[W-1:0]};
    endfunction

    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic ts, input logic tc);
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called 1ns after the start edge; returns cycles until done and busy cycle count.
    task automatic wait_done(output int cycles, output int busy_cnt, output bit timeout);
        cycles = 0; busy_cnt = 0; timeout = 0;
        while (!done) begin
            if (busy) busy_cnt++;
            if (cycles >= 20) begin
                timeout = 1;
                return;
            end
            @(posedge clk);
            #1 cycles++;
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({busy, done, cout, ovf, sum} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [6] = '{16'h1234, 16'hFFFF, 16'h0005, 16'h0009, 16'h7FFF, 16'h8000};
        logic [W-1:0] vb [6] = '{16'h0FCC, 16'h0000, 16'h0007, 16'h0003, 16'h0001, 16'h0001};
        logic         vs [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic         vc [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [W+1:0] ve [6] = '{{2'b00, 16'h2200}, {2'b10, 16'h0000}, {2'b00, 16'hFFFE},
                                 {2'b10, 16'h0005}, {2'b01, 16'h8000}, {2'b11, 16'h7FFF}};
        int cyc, bc;
        bit to;
        for (int i = 0; i < 6; i++) begin
            launch(va[i], vb[i], vs[i], vc[i]);
            wait_done(cyc, bc, to);
            n_cmp++;
            if (to || {cout, ovf, sum} !== ve[i]) begin
                n_err++;
                $display("FAIL directed_%0d: got cout=%b ovf=%b sum=%h timeout=%0d, want %h",
                         i, cout, ovf, sum, to, ve[i]);
            end
            if (i == 0) begin
                n_cmp++;
                if (cyc != N || bc != N) begin
                    n_err++;
                    $display("FAIL latency: got done after %0d, busy %0d cycles, want %0d/%0d",
                             cyc, bc, N, N);
                end
                @(posedge clk);
                #1 n_cmp++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL done_width: got done=%b busy=%b after pulse, want 0/0",
                             done, busy);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        logic         rs, rc;
        logic [W+1:0] exp_v;
        int cyc, bc;
        bit to;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            rs = 1'($urandom); rc = 1'($urandom);
            exp_v = model(ra, rb, rs, rc);
            launch(ra, rb, rs, rc);
            wait_done(cyc, bc, to);
            n_cmp++;
            if (to || cyc != N || {cout, ovf, sum} !== exp_v) begin
                n_err++;
                $display("FAIL random_%0d: a=%h b=%h sub=%b cin=%b got %b/%b/%h cyc=%0d, want %h",
                         i, ra, rb, rs, rc, cout, ovf, sum, cyc, exp_v);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W+1:0] exp_v;
        int cyc, bc;
        bit to;
        exp_v = model(16'h4321, 16'h1111, 1'b1, 1'b0);
        launch(16'h4321, 16'h1111, 1'b1, 1'b0);
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; sub = 1'b0; cin = 1'b1; start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        #1 wait_done(cyc, bc, to);
        n_cmp++;
        if (to || {cout, ovf, sum} !== exp_v) begin
            n_err++;
            $display("FAIL ignore_start: got %b/%b/%h, want %h", cout, ovf, sum, exp_v);
        end
        @(posedge clk);
        #1 n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_start_idle: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_input_change();
        logic [W+1:0] exp_v;
        int cyc, bc;
        bit to;
        exp_v = model(16'h0F0F, 16'hF0F1, 1'b0, 1'b0);
        launch(16'h0F0F, 16'hF0F1, 1'b0, 1'b0);
        for (int i = 0; i < N - 1; i++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); sub = ~sub; cin = ~cin;
        end
        wait_done(cyc, bc, to);
        n_cmp++;
        if (to || {cout, ovf, sum} !== exp_v) begin
            n_err++;
            $display("FAIL input_change: got %b/%b/%h, want %h", cout, ovf, sum, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] e1, e2;
        int cyc, bc;
        bit to;
        e1 = model(16'h1357, 16'h2468, 1'b0, 1'b1);
        e2 = model(16'h0100, 16'h0200, 1'b1, 1'b0);
        launch(16'h1357, 16'h2468, 1'b0, 1'b1);
        repeat (N - 1) @(posedge clk);
        @(negedge clk);
        a = 16'h0100; b = 16'h0200; sub = 1'b1; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 n_cmp++;
        if (done !== 1'b1 || {cout, ovf, sum} !== e1) begin
            n_err++;
            $display("FAIL b2b_first: got done=%b %b/%b/%h, want 1 %h", done, cout, ovf, sum, e1);
        end
        @(posedge clk);
        #1 start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_restart: got busy=%b done=%b, want 1/0", busy, done);
        end
        wait_done(cyc, bc, to);
        n_cmp++;
        if (to || cyc != N || {cout, ovf, sum} !== e2) begin
            n_err++;
            $display("FAIL b2b_second: got %b/%b/%h after %0d, want %h after %0d",
                     cout, ovf, sum, cyc, e2, N);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W+1:0] exp_v;
        int cyc, bc;
        bit to;
        bit saw_done;
        launch(16'hFFF0, 16'h0033, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 n_cmp++;
        if ({busy, done, cout, ovf, sum} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_run: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        n_cmp++;
        if (saw_done || sum !== '0) begin
            n_err++;
            $display("FAIL reset_abort: got activity=%0d sum=%h, want 0/0000", saw_done, sum);
        end
        exp_v = model(16'hABCD, 16'h1234, 1'b1, 1'b1);
        launch(16'hABCD, 16'h1234, 1'b1, 1'b1);
        wait_done(cyc, bc, to);
        n_cmp++;
        if (to || {cout, ovf, sum} !== exp_v) begin
            n_err++;
            $display("FAIL after_reset: got %b/%b/%h, want %h", cout, ovf, sum, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_input_change();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
